// File: rtl/basic_merger.sv
// Two-input toggle-pulse merger: one output toggle per DEAD_CYCLES+1 edges, 1-edge latency from idle.
// Excess pulses queue up to QUEUE_DEPTH (0 = drop mode); overflow is counted in a saturating drop_count.
module basic_merger #(
    parameter int DEAD_CYCLES = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 16,
    localparam int PW         = (QUEUE_DEPTH > 0) ? $clog2(QUEUE_DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1,
    input  logic             in2,
    output logic             out,
    output logic             busy,
    output logic [PW-1:0]    pending,
    output logic             collision,
    output logic [CNT_W-1:0] drop_count
);

    localparam int GW = $clog2(DEAD_CYCLES + 1);
    localparam int DW = PW + 2;
    localparam logic [GW-1:0] DEAD_G = GW'(DEAD_CYCLES);
    localparam logic [DW-1:0] QD_W   = DW'(QUEUE_DEPTH);

    logic             in1_q, in2_q;
    logic             out_q, out_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic             collision_q, collision_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    logic             ev1, ev2, emit;
    logic [DW-1:0]    demand, remain, kept, excess;
    logic [CNT_W:0]   cnt_sum;

    always_comb begin
        ev1     = in1 ^ in1_q;
        ev2     = in2 ^ in2_q;
        demand  = DW'(pending_q) + DW'(ev1) + DW'(ev2);
        emit    = (gap_q == '0) && (demand != '0);
        remain  = emit ? (demand - DW'(1)) : demand;
        kept    = (remain > QD_W) ? QD_W : remain;
        excess  = remain - kept;

        out_d       = out_q ^ emit;
        pending_d   = PW'(kept);
        collision_d = ev1 & ev2;

        if (emit) begin
            gap_d = DEAD_G;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end else begin
            gap_d = gap_q;
        end

        // The emitted pulse is already excluded from excess, so saturation never blocks a toggle.
        cnt_sum      = {1'b0, drop_count_q} + (CNT_W + 1)'(excess);
        drop_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        // Input samples track through reset so held levels produce no event on release.
        in1_q <= in1;
        in2_q <= in2;
        if (rst) begin
            out_q        <= 1'b0;
            gap_q        <= '0;
            pending_q    <= '0;
            collision_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            out_q        <= out_d;
            gap_q        <= gap_d;
            pending_q    <= pending_d;
            collision_q  <= collision_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out        = out_q;
    assign busy       = (gap_q != '0) || (pending_q != '0);
    assign pending    = pending_q;
    assign collision  = collision_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_basic_merger.sv
// Directed bench for basic_merger: queued instance, drop-mode instance and a narrow-counter instance share stimulus.
module tb_basic_merger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in1, in2;

    logic        out_q4, busy_q4, coll_q4;
    logic [2:0]  pend_q4;
    logic [15:0] dc_q4;

    logic        out_d0, busy_d0, coll_d0;
    logic [0:0]  pend_d0;
    logic [15:0] dc_d0;

    logic        out_s, busy_s, coll_s;
    logic [0:0]  pend_s;
    logic [1:0]  dc_s;

    int checks = 0;
    int errors = 0;

    basic_merger #(.DEAD_CYCLES(2), .QUEUE_DEPTH(4), .CNT_W(16)) u_q4 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out_q4), .busy(busy_q4),
        .pending(pend_q4), .collision(coll_q4), .drop_count(dc_q4));

    basic_merger #(.DEAD_CYCLES(2), .QUEUE_DEPTH(0), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out_d0), .busy(busy_d0),
        .pending(pend_d0), .collision(coll_d0), .drop_count(dc_d0));

    basic_merger #(.DEAD_CYCLES(2), .QUEUE_DEPTH(0), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .out(out_s), .busy(busy_s),
        .pending(pend_s), .collision(coll_s), .drop_count(dc_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in1 = 1'b0; in2 = 1'b0;
        tick(); tick();
        checks++; if (out_q4 !== 1'b0)   begin errors++; $display("FAIL reset_out got=%0b exp=0", out_q4); end
        checks++; if (busy_q4 !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy_q4); end
        checks++; if (pend_q4 !== 3'd0)  begin errors++; $display("FAIL reset_pending got=%0d exp=0", pend_q4); end
        checks++; if (coll_q4 !== 1'b0)  begin errors++; $display("FAIL reset_collision got=%0b exp=0", coll_q4); end
        checks++; if (dc_q4 !== 16'd0)   begin errors++; $display("FAIL reset_drop got=%0d exp=0", dc_q4); end
        checks++; if (dc_d0 !== 16'd0)   begin errors++; $display("FAIL reset_drop_d0 got=%0d exp=0", dc_d0); end
        rst = 1'b0;
        tick();
        checks++; if (out_q4 !== 1'b0)   begin errors++; $display("FAIL reset_release_out got=%0b exp=0", out_q4); end
    endtask

    task automatic test_single();
        in1 = 1'b1;
        checks++; if (out_q4 !== 1'b0)  begin errors++; $display("FAIL single_pre_out got=%0b exp=0", out_q4); end
        tick();
        checks++; if (out_q4 !== 1'b1)  begin errors++; $display("FAIL single_out got=%0b exp=1", out_q4); end
        checks++; if (busy_q4 !== 1'b1) begin errors++; $display("FAIL single_busy0 got=%0b exp=1", busy_q4); end
        checks++; if (pend_q4 !== 3'd0) begin errors++; $display("FAIL single_pending got=%0d exp=0", pend_q4); end
        tick();
        checks++; if (busy_q4 !== 1'b1) begin errors++; $display("FAIL single_busy1 got=%0b exp=1", busy_q4); end
        checks++; if (out_q4 !== 1'b1)  begin errors++; $display("FAIL single_hold got=%0b exp=1", out_q4); end
        tick();
        checks++; if (busy_q4 !== 1'b0) begin errors++; $display("FAIL single_busy2 got=%0b exp=0", busy_q4); end
        checks++; if (dc_q4 !== 16'd0)  begin errors++; $display("FAIL single_drop got=%0d exp=0", dc_q4); end
    endtask

    task automatic test_coincident();
        do_reset();
        in1 = 1'b0; in2 = 1'b1;
        tick();
        checks++; if (out_q4 !== 1'b1)  begin errors++; $display("FAIL coin_out_n got=%0b exp=1", out_q4); end
        checks++; if (coll_q4 !== 1'b1) begin errors++; $display("FAIL coin_collision got=%0b exp=1", coll_q4); end
        checks++; if (pend_q4 !== 3'd1) begin errors++; $display("FAIL coin_pending_n got=%0d exp=1", pend_q4); end
        checks++; if (out_d0 !== 1'b1)  begin errors++; $display("FAIL drop_out_n got=%0b exp=1", out_d0); end
        checks++; if (pend_d0 !== 1'b0) begin errors++; $display("FAIL drop_pending got=%0d exp=0", pend_d0); end
        checks++; if (dc_d0 !== 16'd1)  begin errors++; $display("FAIL drop_count_n got=%0d exp=1", dc_d0); end
        checks++; if (coll_d0 !== 1'b1) begin errors++; $display("FAIL drop_collision got=%0b exp=1", coll_d0); end
        tick();
        checks++; if (coll_q4 !== 1'b0) begin errors++; $display("FAIL coin_collision_clr got=%0b exp=0", coll_q4); end
        checks++; if (pend_q4 !== 3'd1) begin errors++; $display("FAIL coin_pending_n1 got=%0d exp=1", pend_q4); end
        tick();
        checks++; if (pend_q4 !== 3'd1) begin errors++; $display("FAIL coin_pending_n2 got=%0d exp=1", pend_q4); end
        checks++; if (out_q4 !== 1'b1)  begin errors++; $display("FAIL coin_out_n2 got=%0b exp=1", out_q4); end
        tick();
        checks++; if (out_q4 !== 1'b0)  begin errors++; $display("FAIL coin_out_n3 got=%0b exp=0", out_q4); end
        checks++; if (pend_q4 !== 3'd0) begin errors++; $display("FAIL coin_pending_n3 got=%0d exp=0", pend_q4); end
        checks++; if (dc_q4 !== 16'd0)  begin errors++; $display("FAIL coin_drop got=%0d exp=0", dc_q4); end
        checks++; if (out_d0 !== 1'b1)  begin errors++; $display("FAIL drop_out_n3 got=%0b exp=1", out_d0); end
        checks++; if (dc_d0 !== 16'd1)  begin errors++; $display("FAIL drop_count_n3 got=%0d exp=1", dc_d0); end
    endtask

    task automatic test_burst();
        int exp_pend [0:21] = '{0,1,2,2,3,4,4,4,4,3,3,3,2,2,2,1,1,1,0,0,0,0};
        logic exp_out;
        logic exp_busy;
        logic [15:0] exp_dc;
        int peak;
        do_reset();
        exp_out = 1'b0;
        peak = 0;
        for (int e = 0; e < 22; e++) begin
            if (e < 8) in1 = ~in1;
            tick();
            if ((e % 3 == 0) && (e <= 18)) exp_out = ~exp_out;
            exp_busy = (e <= 19);
            exp_dc   = (e >= 7) ? 16'd1 : 16'd0;
            if (int'(pend_q4) > peak) peak = int'(pend_q4);
            checks++; if (out_q4 !== exp_out)
                begin errors++; $display("FAIL burst_out edge=%0d got=%0b exp=%0b", e, out_q4, exp_out); end
            checks++; if (pend_q4 !== 3'(exp_pend[e]))
                begin errors++; $display("FAIL burst_pending edge=%0d got=%0d exp=%0d", e, pend_q4, exp_pend[e]); end
            checks++; if (busy_q4 !== exp_busy)
                begin errors++; $display("FAIL burst_busy edge=%0d got=%0b exp=%0b", e, busy_q4, exp_busy); end
            checks++; if (dc_q4 !== exp_dc)
                begin errors++; $display("FAIL burst_drop edge=%0d got=%0d exp=%0d", e, dc_q4, exp_dc); end
        end
        checks++; if (peak != 4) begin errors++; $display("FAIL burst_peak got=%0d exp=4", peak); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in1 = ~in1; in2 = ~in2;
        tick();
        checks++; if (pend_q4 !== 3'd1) begin errors++; $display("FAIL mid_pending0 got=%0d exp=1", pend_q4); end
        in1 = ~in1;
        tick();
        in2 = ~in2;
        tick();
        checks++; if (pend_q4 !== 3'd3) begin errors++; $display("FAIL mid_pending_pre got=%0d exp=3", pend_q4); end
        checks++; if (out_q4 !== 1'b1)  begin errors++; $display("FAIL mid_out_pre got=%0b exp=1", out_q4); end
        rst = 1'b1;
        in1 = ~in1;
        tick();
        rst = 1'b0;
        checks++; if (out_q4 !== 1'b0)  begin errors++; $display("FAIL mid_out got=%0b exp=0", out_q4); end
        checks++; if (pend_q4 !== 3'd0) begin errors++; $display("FAIL mid_pending got=%0d exp=0", pend_q4); end
        checks++; if (dc_q4 !== 16'd0)  begin errors++; $display("FAIL mid_drop got=%0d exp=0", dc_q4); end
        checks++; if (busy_q4 !== 1'b0) begin errors++; $display("FAIL mid_busy got=%0b exp=0", busy_q4); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_q4 !== 1'b0)
                begin errors++; $display("FAIL mid_quiet_out cyc=%0d got=%0b exp=0", i, out_q4); end
            checks++; if (busy_q4 !== 1'b0)
                begin errors++; $display("FAIL mid_quiet_busy cyc=%0d got=%0b exp=0", i, busy_q4); end
        end
        in1 = ~in1;
        tick();
        checks++; if (out_q4 !== 1'b1) begin errors++; $display("FAIL mid_first_event got=%0b exp=1", out_q4); end
    endtask

    task automatic test_held();
        rst = 1'b1;
        in1 = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (out_q4 !== 1'b0) begin errors++; $display("FAIL held_reset_out got=%0b exp=0", out_q4); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_q4 !== 1'b0)
                begin errors++; $display("FAIL held_out cyc=%0d got=%0b exp=0", i, out_q4); end
            checks++; if (busy_q4 !== 1'b0)
                begin errors++; $display("FAIL held_busy cyc=%0d got=%0b exp=0", i, busy_q4); end
        end
        in1 = 1'b0;
        checks++; if (out_q4 !== 1'b0) begin errors++; $display("FAIL held_pre_edge got=%0b exp=0", out_q4); end
        tick();
        checks++; if (out_q4 !== 1'b1) begin errors++; $display("FAIL held_fall_out got=%0b exp=1", out_q4); end
    endtask

    task automatic test_saturate();
        logic       exp_out;
        logic [1:0] exp_dc;
        do_reset();
        exp_out = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in1 = ~in1; in2 = ~in2;
            tick();
            exp_out = ~exp_out;
            exp_dc  = (k >= 3) ? 2'd3 : 2'(k);
            checks++; if (out_s !== exp_out)
                begin errors++; $display("FAIL sat_out k=%0d got=%0b exp=%0b", k, out_s, exp_out); end
            checks++; if (dc_s !== exp_dc)
                begin errors++; $display("FAIL sat_drop k=%0d got=%0d exp=%0d", k, dc_s, exp_dc); end
            checks++; if (dc_d0 !== 16'(k))
                begin errors++; $display("FAIL wide_drop k=%0d got=%0d exp=%0d", k, dc_d0, k); end
            tick(); tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in1 = 1'b0; in2 = 1'b0;
        test_reset();
        test_single();
        test_coincident();
        test_burst();
        test_reset_mid();
        test_held();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
